// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES S-boxes substitute one byte group per cycle.
// Optional macro INV_SBOX_EN adds the inv port and the inverse S-box (InvSubBytes).
`timescale 1ns/1ps
module sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
`ifdef INV_SBOX_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int DATA_W = 128;
  localparam int GROUPS = 16 / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST_GRP = CW'(GROUPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD[2047 - 8*int'(b) -: 8];
  endfunction

`ifdef INV_SBOX_EN
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[2047 - 8*int'(b) -: 8];
  endfunction

  logic inv_q;
`endif

  function automatic logic [7:0] lane_sub(input logic [7:0] b, input logic use_inv);
`ifdef INV_SBOX_EN
    return use_inv ? sbox_inv(b) : sbox_fwd(b);
`else
    return (use_inv === 1'bx) ? 8'h00 : sbox_fwd(b);
`endif
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     grp_q;
  logic [DATA_W-1:0] work_q, work_sub;
  logic              last_grp, sel_inv;

  assign last_grp = (grp_q == LAST_GRP);
`ifdef INV_SBOX_EN
  assign sel_inv = inv_q;
`else
  assign sel_inv = 1'b0;
`endif

  // Substitute the current group; bytes outside it pass through untouched
  always_comb begin
    int base;
    work_sub = work_q;
    base     = int'(grp_q) * LANES;
    for (int l = 0; l < LANES; l++) begin
      work_sub[127 - 8*(base + l) -: 8] = lane_sub(work_q[127 - 8*(base + l) -: 8], sel_inv);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_grp)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == BUSY);
    out_valid = (state_q == DONE);
  end

  // Working register, group counter and the held result
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q   <= '0;
      grp_q    <= '0;
      data_out <= '0;
`ifdef INV_SBOX_EN
      inv_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          work_q <= data_in;
          grp_q  <= '0;
`ifdef INV_SBOX_EN
          inv_q  <= inv;
`endif
        end
        BUSY: begin
          work_q <= work_sub;
          if (last_grp) begin
            grp_q    <= '0;
            data_out <= work_sub;
          end else begin
            grp_q <= grp_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed self-checking bench for sub_bytes_iter (LANES=4; inverse tests when INV_SBOX_EN is defined).
`timescale 1ns/1ps
module tb_sub_bytes_iter;
  localparam int LANES = 4;
  localparam int LAT   = 16 / LANES;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, in_ready, out_valid, busy;
  logic [127:0] data_in, data_out;
`ifdef INV_SBOX_EN
  logic         inv = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] V_AES  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] E_AES  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] V_SEQ  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E_SEQ  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] ALL_00 = {16{8'h00}};
  localparam logic [127:0] ALL_63 = {16{8'h63}};
  localparam logic [127:0] ALL_FF = {16{8'hff}};
  localparam logic [127:0] ALL_16 = {16{8'h16}};

  sub_bytes_iter #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
`ifdef INV_SBOX_EN
    .inv(inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_one(input string tag, input logic [127:0] din, input logic [127:0] exp);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    in_valid = 1'b1;
    data_in  = din;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, {127'b0, busy}, 128'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk({tag, "_latency"}, 128'(lat), 128'(LAT));
    chk({tag, "_data"}, data_out, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ovalid_clr"}, {127'b0, out_valid}, 128'd0);
  endtask

  initial begin
    logic [127:0] held;
    logic [127:0] bb_in [3];
    logic [127:0] bb_exp[3];
    int lat, acc, res, last_cyc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
    tick();
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_data_out", data_out, 128'd0);
    rst = 1'b0;
    tick();

    run_one("aes_vec", V_AES, E_AES);
    run_one("all00", ALL_00, ALL_63);
    run_one("allff", ALL_FF, ALL_16);
    run_one("seq", V_SEQ, E_SEQ);

    // Backpressure: result held while a new input waits
    in_valid = 1'b1; data_in = V_AES;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("bp_first_ready", {127'b0, out_valid}, 128'd1);
    held = data_out;
    in_valid = 1'b1; data_in = V_SEQ;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_stable", data_out, E_AES);
      chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
    end
    chk("bp_held", data_out, held);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_hs_ovalid", {127'b0, out_valid}, 128'd0);
    chk("bp_hs_in_ready", {127'b0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("bp_second_latency", 128'(lat), 128'(LAT));
    chk("bp_second_data", data_out, E_SEQ);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of BUSY discards the state
    in_valid = 1'b1; data_in = V_AES;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("midrst_data_out", data_out, 128'd0);
    chk("midrst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("midrst_busy", {127'b0, busy}, 128'd0);
    run_one("post_rst", V_SEQ, E_SEQ);

    // Back-to-back with out_ready held high
    bb_in[0] = V_AES;  bb_exp[0] = E_AES;
    bb_in[1] = ALL_FF; bb_exp[1] = ALL_16;
    bb_in[2] = V_SEQ;  bb_exp[2] = E_SEQ;
    acc = 0; res = 0; last_cyc = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (out_valid) begin
        if (res < 3) chk("b2b_data", data_out, bb_exp[res]);
        else         chk("b2b_extra_result", {127'b0, out_valid}, 128'd0);
        if (last_cyc >= 0) chk("b2b_spacing", 128'(cyc - last_cyc), 128'(LAT + 2));
        last_cyc = cyc;
        res++;
      end
      if (in_ready && acc < 3) begin
        in_valid = 1'b1;
        data_in  = bb_in[acc];
        acc++;
      end else begin
        in_valid = (acc < 3);
      end
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_count", 128'(res), 128'd3);

`ifdef INV_SBOX_EN
    inv = 1'b1;
    in_valid = 1'b1; data_in = E_AES;
    tick();
    in_valid = 1'b0;
    inv = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("inv_latency", 128'(lat), 128'(LAT));
    chk("inv_aes", data_out, V_AES);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    inv = 1'b1;
    run_one("inv_63", ALL_63, ALL_00);
    inv = 1'b0;
    run_one("fwd_after_inv", ALL_00, ALL_63);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
